// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] DEFAULT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte idle counter; expire_c fires on the idle cycle that reaches TIMEOUT.
module prog_loader_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic en,
  input  logic clr,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Count idle cycles while enabled; any accepted byte or leaving the frame clears.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A byte in the same cycle (clr) always beats expiry.
  assign expire_c = en && !clr && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses MAGIC/len/LE words/XOR frames from UART and writes memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 11,
  parameter logic [BYTE_W-1:0] MAGIC   = DEFAULT_MAGIC,
  parameter int unsigned       TIMEOUT = 0
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rx_valid,
  input  logic [BYTE_W-1:0] w_rx_data,
  output logic              r_mem_we,
  output logic [ADDR_W-1:0] r_mem_addr,
  output logic [WORD_W-1:0] r_mem_din,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err,
  output logic [1:0]        r_err_code,
  output logic [ADDR_W:0]   r_words
);

  localparam int unsigned WCNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W  = (WCNT_W > LEN_W + 1) ? WCNT_W : LEN_W + 1;
  localparam logic [CMP_W-1:0]  LEN_MAX   = CMP_W'(1) << ADDR_W;
  localparam logic [WCNT_W-1:0] WORDS_MAX = WCNT_W'(1) << ADDR_W;

  state_e              state, state_nxt;
  logic [LEN_W-1:0]    len_q, len_nxt;
  logic [1:0]          idx_q, idx_nxt;
  logic [23:0]         word_q, word_nxt;
  logic [BYTE_W-1:0]   csum_q, csum_nxt;
  logic [WCNT_W-1:0]   words_nxt;
  logic                we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [WORD_W-1:0]   din_nxt;
  logic                proc_rst_nxt, done_nxt, err_nxt;
  logic [1:0]          code_nxt;

  logic [LEN_W-1:0]    len_full;
  logic                len_bad;
  logic                is_magic;
  logic [WCNT_W-1:0]   words_inc;
  logic                last_word;
  logic                tmo_expire_c;

  // Frame helpers: full length on the high byte, saturating word count, last-word match.
  assign len_full  = {w_rx_data, len_q[7:0]};
  assign len_bad   = (len_full == '0) || (CMP_W'(len_full) > LEN_MAX);
  assign is_magic  = w_rx_valid && (w_rx_data == MAGIC);
  assign words_inc = (r_words == WORDS_MAX) ? r_words : r_words + WCNT_W'(1);
  assign last_word = (CMP_W'(words_inc) == CMP_W'(len_q));

  // Timeout only watches the in-frame states; tied off when disabled.
  generate
    if (TIMEOUT > 0) begin : g_tmo
      logic in_frame;
      assign in_frame = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
      prog_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .en       (in_frame),
        .clr      (w_rx_valid || !in_frame),
        .expire_c (tmo_expire_c)
      );
    end else begin : g_no_tmo
      assign tmo_expire_c = 1'b0;
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      r_words    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      len_q      <= len_nxt;
      idx_q      <= idx_nxt;
      word_q     <= word_nxt;
      csum_q     <= csum_nxt;
      r_words    <= words_nxt;
      r_mem_we   <= we_nxt;
      r_mem_addr <= addr_nxt;
      r_mem_din  <= din_nxt;
      r_proc_rst <= proc_rst_nxt;
      r_done     <= done_nxt;
      r_err      <= err_nxt;
      r_err_code <= code_nxt;
    end
  end

  // Frame parser: next state, word assembly, checksum and status.
  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    idx_nxt      = idx_q;
    word_nxt     = word_q;
    csum_nxt     = csum_q;
    words_nxt    = r_words;
    we_nxt       = 1'b0;
    addr_nxt     = r_mem_addr;
    din_nxt      = r_mem_din;
    proc_rst_nxt = r_proc_rst;
    done_nxt     = r_done;
    err_nxt      = r_err;
    code_nxt     = r_err_code;

    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (is_magic) begin
          state_nxt    = ST_LEN_LO;
          len_nxt      = '0;
          idx_nxt      = '0;
          csum_nxt     = '0;
          words_nxt    = '0;
          proc_rst_nxt = 1'b1;
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          code_nxt     = ERR_NONE;
        end
      end
      ST_LEN_LO: begin
        if (w_rx_valid) begin
          len_nxt[7:0] = w_rx_data;
          state_nxt    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (w_rx_valid) begin
          len_nxt = len_full;
          idx_nxt = '0;
          if (len_bad) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
            code_nxt  = ERR_LEN;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_valid) begin
          csum_nxt = csum_q ^ w_rx_data;
          idx_nxt  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: word_nxt[7:0]   = w_rx_data;
            2'd1: word_nxt[15:8]  = w_rx_data;
            2'd2: word_nxt[23:16] = w_rx_data;
            default: begin
              we_nxt    = 1'b1;
              addr_nxt  = r_words[ADDR_W-1:0];
              din_nxt   = {w_rx_data, word_q};
              words_nxt = words_inc;
              if (last_word) state_nxt = ST_CSUM;
            end
          endcase
        end
      end
      ST_CSUM: begin
        if (w_rx_valid) begin
          if (w_rx_data == csum_q) begin
            state_nxt    = ST_DONE;
            done_nxt     = 1'b1;
            proc_rst_nxt = 1'b0;
          end else begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
            code_nxt  = ERR_CSUM;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Idle-too-long inside a frame aborts it.
    if (tmo_expire_c) begin
      state_nxt = ST_ERR;
      err_nxt   = 1'b1;
      code_nxt  = ERR_TMO;
    end
  end

endmodule
